// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = 8'hFF;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/bto7s.sv
// Hex nibble to seven-segment decoder; segments a..g on bits 0..6, active-high.
import seven_seg_pkg::*;

module bto7s (
  input  nibble_t    x_in,
  output logic [6:0] s_out
);

  // Combinational glyph lookup
  always_comb begin
    s_out = 7'h00;
    case (x_in)
      4'h0:    s_out = 7'h3F;
      4'h1:    s_out = 7'h06;
      4'h2:    s_out = 7'h5B;
      4'h3:    s_out = 7'h4F;
      4'h4:    s_out = 7'h66;
      4'h5:    s_out = 7'h6D;
      4'h6:    s_out = 7'h7D;
      4'h7:    s_out = 7'h07;
      4'h8:    s_out = 7'h7F;
      4'h9:    s_out = 7'h6F;
      4'hA:    s_out = 7'h77;
      4'hB:    s_out = 7'h7C;
      4'hC:    s_out = 7'h39;
      4'hD:    s_out = 7'h5E;
      4'hE:    s_out = 7'h79;
      4'hF:    s_out = 7'h71;
      default: s_out = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with tear-free frame-boundary commit.
// Optional leading-zero blanking when SEVEN_SEG_LZ_BLANK_EN is defined.
import seven_seg_pkg::*;

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    val_valid_in,
  output logic                    val_ready_out,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int CW = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [VW-1:0]         disp_q, disp_d;
  logic [VW-1:0]         pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [6:0]            cat_q, cat_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  nibble_t    nib_s;
  logic [6:0] seg_s;
  logic       slot_end_s, frame_end_s, accept_s, blank_s, lit_s;

  assign nib_s = disp_q[{dig_q, 2'b00} +: 4];

  bto7s u_bto7s (
    .x_in  (nib_s),
    .s_out (seg_s)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [DW-1:0] msd_s;

  // Index of the most significant non-zero nibble; digit 0 stays lit for value 0
  always_comb begin
    msd_s = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) begin
        msd_s = DW'(i);
      end else begin
        msd_s = msd_s;
      end
    end
  end

  assign lit_s = (dig_q <= msd_s);
`else
  assign lit_s = 1'b1;
`endif

  // Scan sequencing, handshake and output decode
  always_comb begin
    slot_end_s  = (cnt_q == CW'(COUNT_PERIOD - 1));
    frame_end_s = slot_end_s && (dig_q == DW'(NUM_DIGITS - 1));
    accept_s    = val_valid_in && !pend_v_q;
    blank_s     = (int'(cnt_q) < BLANK_CYCLES);

    cnt_d    = slot_end_s ? '0 : cnt_q + CW'(1);
    dig_d    = dig_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (slot_end_s) begin
      dig_d = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + DW'(1);
    end else begin
      dig_d = dig_q;
    end

    // Commit and accept are exclusive: accept needs pend_v low, commit needs it high
    if (frame_end_s && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end else if (accept_s) begin
      pend_d   = val_in;
      pend_v_d = 1'b1;
    end else begin
      pend_v_d = pend_v_q;
    end

    an_d  = AN_OFF[NUM_DIGITS-1:0];
    cat_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!blank_s && lit_s) begin
      an_d[dig_q] = 1'b0;
      cat_d       = ~seg_s;
      dp_d        = ~dp_in[dig_q];
    end else begin
      an_d = AN_OFF[NUM_DIGITS-1:0];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      dig_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= AN_OFF[NUM_DIGITS-1:0];
      cat_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      cat_q    <= cat_d;
      dp_q     <= dp_d;
    end
  end

  assign val_ready_out = !pend_v_q;
  assign cat_out       = cat_q;
  assign dp_out        = dp_q;
  assign an_out        = an_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (8 digits, 8-cycle slots, 2 blank cycles).
module tb_seven_seg_scan_ctrl;

  localparam int ND = 8;
  localparam int CP = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * CP;

  // Expected active-low cathode patterns per hex digit
  localparam logic [6:0] SEG_N [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    int         k;
    logic [7:0] an;
    logic [6:0] cat;
    logic       dp;
    logic       rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [31:0] val_in;
  logic        val_valid_in;
  logic        val_ready_out;
  logic [7:0]  dp_in;
  logic [6:0]  cat_out;
  logic        dp_out;
  logic [7:0]  an_out;

  exp_t q[$];
  int   n_tests  = 0;
  int   n_failed = 0;
  bit   done     = 1'b0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .COUNT_PERIOD (CP),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .val_in        (val_in),
    .val_valid_in  (val_valid_in),
    .val_ready_out (val_ready_out),
    .dp_in         (dp_in),
    .cat_out       (cat_out),
    .dp_out        (dp_out),
    .an_out        (an_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s at k=%0d: got %h, expected %h", nm, k, act, exp);
    end
  endtask

  // Reference model state
  int          m_pos;
  logic [31:0] m_disp, m_pend;
  bit          m_pv;

  function automatic exp_t model_edge(input int k);
    exp_t e;
    int   c, d;
    bit   lit;
    e.k = k;
    if (rst_in) begin
      m_pos = 0; m_disp = 32'h0; m_pv = 1'b0;
      e.an = 8'hFF; e.cat = 7'h7F; e.dp = 1'b1; e.rdy = 1'b1;
      return e;
    end
    c = m_pos % CP;
    d = m_pos / CP;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    lit = (d == 0);
    for (int j = 0; j < ND; j++) begin
      if (m_disp[4*j +: 4] != 4'h0 && d <= j) lit = 1'b1;
    end
`else
    lit = 1'b1;
`endif
    if (c < BC || !lit) begin
      e.an = 8'hFF; e.cat = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an  = 8'hFF & ~(8'd1 << d);
      e.cat = SEG_N[m_disp[4*d +: 4]];
      e.dp  = ~dp_in[d];
    end
    if (m_pos == FRAME - 1 && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end else if (val_valid_in && !m_pv) begin
      m_pend = val_in;
      m_pv   = 1'b1;
    end
    m_pos = (m_pos + 1) % FRAME;
    e.rdy = !m_pv;
    return e;
  endfunction

  // Stimulus driver: sets inputs on the falling edge, pushes expectations at the rising edge
  initial begin
    rst_in = 1'b1; val_in = 32'h0; val_valid_in = 1'b0; dp_in = 8'h00;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      q.push_back(model_edge(-1));
    end
    for (int k = 0; k < 430; k++) begin
      @(negedge clk);
      rst_in       = (k == 345 || k == 346);
      val_valid_in = 1'b0;
      val_in       = 32'h0;
      dp_in        = (k >= 260 && k < 330) ? 8'h04 : 8'h00;
      if (k == 70) begin
        val_valid_in = 1'b1; val_in = 32'h89ABCDEF;
      end else if (k == 191) begin
        val_valid_in = 1'b1; val_in = 32'h76543210;
      end else if (k >= 200 && k < 220) begin
        val_valid_in = 1'b1; val_in = 32'hDEAD0000 + k;
      end else if (k == 340) begin
        val_valid_in = 1'b1; val_in = 32'h11111111;
      end
      @(posedge clk);
      q.push_back(model_edge(k));
    end
    @(negedge clk);
    done = 1'b1;
    @(posedge clk);
    #2;
    chk("queue_drained", 0, q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  // Monitor: pops one expectation per cycle and compares, plus hand-computed spot checks
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (q.size() == 0) begin
        chk("scoreboard_empty", -2, 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk("an_out",        e.k, an_out,        e.an);
        chk("cat_out",       e.k, cat_out,       e.cat);
        chk("dp_out",        e.k, dp_out,        e.dp);
        chk("val_ready_out", e.k, val_ready_out, e.rdy);
        case (e.k)
          0:   begin chk("hand_blank_an", 0, an_out, 8'hFF); chk("hand_blank_cat", 0, cat_out, 7'h7F); end
          2:   begin chk("hand_d0_an", 2, an_out, 8'hFE); chk("hand_d0_cat", 2, cat_out, 7'h40); end
`ifdef SEVEN_SEG_LZ_BLANK_EN
          10:  chk("hand_d1_an_lz", 10, an_out, 8'hFF);
`else
          10:  chk("hand_d1_an", 10, an_out, 8'hFD);
`endif
          69:  chk("hand_rdy_before", 69, val_ready_out, 1'b1);
          70:  chk("hand_rdy_fall", 70, val_ready_out, 1'b0);
          126: chk("hand_rdy_held", 126, val_ready_out, 1'b0);
          127: chk("hand_rdy_rise", 127, val_ready_out, 1'b1);
          130: chk("hand_F_cat", 130, cat_out, 7'h0E);
          186: begin chk("hand_8_cat", 186, cat_out, 7'h00); chk("hand_d7_an", 186, an_out, 8'h7F); end
          191: chk("hand_bnd_accept", 191, val_ready_out, 1'b0);
          194: chk("hand_old_frame", 194, cat_out, 7'h0E);
          250: chk("hand_old_d7", 250, cat_out, 7'h00);
          255: chk("hand_bnd_commit", 255, val_ready_out, 1'b1);
          258: chk("hand_new_d0", 258, cat_out, 7'h40);
          266: chk("hand_new_d1", 266, cat_out, 7'h79);
          273: chk("hand_dp_blank", 273, dp_out, 1'b1);
          275: chk("hand_dp_on", 275, dp_out, 1'b0);
          283: chk("hand_dp_other", 283, dp_out, 1'b1);
          345: begin
            chk("hand_rst_an", 345, an_out, 8'hFF);
            chk("hand_rst_cat", 345, cat_out, 7'h7F);
            chk("hand_rst_dp", 345, dp_out, 1'b1);
            chk("hand_rst_rdy", 345, val_ready_out, 1'b1);
          end
          349: begin chk("hand_post_rst_an", 349, an_out, 8'hFE); chk("hand_post_rst_cat", 349, cat_out, 7'h40); end
          default: ;
        endcase
      end
    end
  end

  // Run-time bound
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
